// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, LUT-indexed redirects, stalls,
// and the start/done program handshake.
module pc_sequencer #(
    parameter int D        = 12,
    parameter int HALT_IDX = 31,
    parameter int HALT_PC  = 511,
    parameter int LDI_MAX  = 3,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          jump_en,
    input  logic          branch_en,
    input  logic [4:0]    lut_idx,
    output logic [4:0]    lut_addr,
    input  logic [D-1:0]  lut_target,
    output logic [D-1:0]  prog_ctr,
    output logic          fetch_valid,
    output logic          done,
    output logic          bad_target,
    output logic [CW-1:0] retired
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0]   LDI_L  = LDI_MAX[4:0];
    localparam logic [4:0]   HIDX_L = HALT_IDX[4:0];
    localparam logic [D-1:0] HPC_L  = HALT_PC[D-1:0];

    logic [1:0]    state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic          bad_q, bad_d;
    logic [CW-1:0] ret_q, ret_d;
    logic          redir;
    logic          legal;

    assign redir = jump_en | branch_en;
    assign legal = lut_idx > LDI_L;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        bad_d   = bad_q;
        ret_d   = ret_q;
        case (state_q)
            S_RUN: begin
                if (!stall) begin
                    if (ret_q != '1) begin
                        ret_d = ret_q + 1'b1;
                    end
                    if (redir && !legal) begin
                        bad_d = 1'b1;
                    end
                    if (redir && legal) begin
                        pc_d = lut_target;
                        if (lut_idx == HIDX_L || lut_target == HPC_L) begin
                            state_d = S_DONE;
                        end
                    end else if (pc_q == '1) begin
                        // No wrap: overflow ends the program in place.
                        bad_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_q + 1'b1;
                        if (pc_d == HPC_L) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    bad_d   = 1'b0;
                    ret_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            bad_q   <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bad_q   <= bad_d;
            ret_q   <= ret_d;
        end
    end

    assign lut_addr    = lut_idx;
    assign prog_ctr    = pc_q;
    assign fetch_valid = (state_q == S_RUN) && !stall;
    assign done        = (state_q == S_DONE);
    assign bad_target  = bad_q;
    assign retired     = ret_q;

endmodule
